// File: rtl/fsms_menu_pkg.sv
// rtl/fsms_menu_pkg.sv - shared states, RTC address table and reset constants for fsms_menu
package fsms_menu_pkg;

  typedef enum logic [2:0] {INIT, READ, DECIDE, EDIT, WRITE} state_t;

  localparam int READ_LEN  = 10;
  localparam int WRITE_LEN = 9;
  localparam logic [6:0] PUNT_RST = 7'b0000001;

  localparam logic [6:0] ADDR_TABLE [10] = '{
    7'h21, 7'h22, 7'h23, 7'h24, 7'h25, 7'h26, 7'h41, 7'h42, 7'h43, 7'h44
  };

  function automatic logic [6:0] addr_at(input logic [3:0] idx);
    addr_at = (idx < 4'd10) ? ADDR_TABLE[idx] : 7'h00;
  endfunction

endpackage

// File: rtl/fsms_menu_if.sv
// rtl/fsms_menu_if.sv - button/IRQ inputs and RTC bus-control outputs of fsms_menu
interface fsms_menu_if;
  logic       IRQ, Barriba, Babajo, Bderecha, Bizquierda, Bcentro, FRW;
  logic       Acceso, Mod, Alarma, STW, Numup, Numdown;
  logic [6:0] Dir, Punt;

  modport master (
    output IRQ, Barriba, Babajo, Bderecha, Bizquierda, Bcentro, FRW,
    input  Acceso, Mod, Alarma, STW, Numup, Numdown, Dir, Punt
  );

  modport slave (
    input  IRQ, Barriba, Babajo, Bderecha, Bizquierda, Bcentro, FRW,
    output Acceso, Mod, Alarma, STW, Numup, Numdown, Dir, Punt
  );
endinterface

// File: rtl/fsms_menu_addr_seq.sv
// rtl/fsms_menu_addr_seq.sv - steps Dir through the RTC address table, ACC_CYC cycles per entry
module fsms_menu_addr_seq
  import fsms_menu_pkg::*;
#(
  parameter int ACC_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       mode,
  output logic [6:0] dir,
  output logic       valid,
  output logic       done
);
  localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic          wr;
  logic          hold_end, last_entry;

  assign hold_end   = (cnt == CW'(ACC_CYC - 1));
  assign last_entry = (idx == (wr ? 4'(WRITE_LEN - 1) : 4'(READ_LEN - 1)));
  assign done       = valid && hold_end && last_entry;

  // Dir keeps its last address after a sweep so DECIDE still shows 7'h44.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt   <= '0;
      idx   <= '0;
      wr    <= 1'b0;
      valid <= 1'b0;
      dir   <= 7'h00;
    end else if (start) begin
      cnt   <= '0;
      idx   <= '0;
      wr    <= mode;
      valid <= 1'b1;
      dir   <= addr_at(4'd0);
    end else if (valid) begin
      if (hold_end) begin
        cnt <= '0;
        if (last_entry) begin
          valid <= 1'b0;
        end else begin
          idx <= idx + 4'd1;
          dir <= addr_at(idx + 4'd1);
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/fsms_menu.sv
// rtl/fsms_menu.sv - RTC menu/control FSM; FSMS_MENU_ALARM_TIMEOUT_EN enables Alarma auto-clear
module fsms_menu
  import fsms_menu_pkg::*;
#(
  parameter int ACC_CYC   = 4,
  parameter int ALARM_CYC = 1000
) (
  input  logic     CLK,
  input  logic     RST,
  fsms_menu_if.slave bus
);
`ifdef FSMS_MENU_ALARM_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int AW = $clog2(ALARM_CYC + 1);

  state_t        state, next_state;
  logic          start, seq_mode, seq_done, seq_valid;
  logic [6:0]    seq_dir;
  logic [6:0]    punt, punt_n;
  logic          numup, numup_n, numdown, numdown_n;
  logic          alarma, alarm_n, irq_pend, pend_n, pend_eff;
  logic [AW-1:0] alarm_cnt;
  logic          alarm_expire;

  fsms_menu_addr_seq #(.ACC_CYC(ACC_CYC)) u_seq (
    .CLK(CLK), .RST(RST), .start(start), .mode(seq_mode),
    .dir(seq_dir), .valid(seq_valid), .done(seq_done)
  );

  assign pend_eff     = irq_pend || (bus.IRQ && state != INIT);
  assign alarm_expire = TIMEOUT_EN && alarma && (alarm_cnt == AW'(ALARM_CYC - 1));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    seq_mode   = 1'b0;
    punt_n     = punt;
    numup_n    = 1'b0;
    numdown_n  = 1'b0;
    alarm_n    = alarma && !alarm_expire;
    pend_n     = pend_eff;
    case (state)
      INIT: begin
        if (bus.FRW) begin
          next_state = READ;
          start      = 1'b1;
        end
      end
      READ: begin
        if (seq_done) next_state = DECIDE;
      end
      DECIDE: begin
        if (bus.Bcentro) begin
          next_state = EDIT;
          alarm_n    = 1'b0;
          pend_n     = 1'b0;
        end else begin
          if (pend_eff) begin
            alarm_n = 1'b1;
            pend_n  = 1'b0;
          end
          next_state = READ;
          start      = 1'b1;
        end
      end
      EDIT: begin
        // Up/down outranks the pointer arrows; opposing pairs cancel.
        if (bus.Bcentro) begin
          next_state = WRITE;
          start      = 1'b1;
          seq_mode   = 1'b1;
        end else if (bus.Barriba || bus.Babajo) begin
          numup_n   = bus.Barriba && !bus.Babajo;
          numdown_n = bus.Babajo && !bus.Barriba;
        end else if (bus.Bderecha && !bus.Bizquierda) begin
          punt_n = {punt[5:0], punt[6]};
        end else if (bus.Bizquierda && !bus.Bderecha) begin
          punt_n = {punt[0], punt[6:1]};
        end
      end
      WRITE: begin
        if (seq_done) begin
          next_state = READ;
          start      = 1'b1;
        end
      end
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      punt     <= PUNT_RST;
      numup    <= 1'b0;
      numdown  <= 1'b0;
      alarma   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      punt     <= punt_n;
      numup    <= numup_n;
      numdown  <= numdown_n;
      alarma   <= alarm_n;
      irq_pend <= pend_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST || !alarma || alarm_expire) begin
      alarm_cnt <= '0;
    end else begin
      alarm_cnt <= alarm_cnt + AW'(1);
    end
  end

  assign bus.Acceso  = seq_valid;
  assign bus.Dir     = seq_dir;
  assign bus.Mod     = (state == EDIT);
  assign bus.STW     = (state == WRITE);
  assign bus.Punt    = punt;
  assign bus.Numup   = numup;
  assign bus.Numdown = numdown;
  assign bus.Alarma  = alarma;
endmodule

// File: tb/tb_fsms_menu.sv
// tb/tb_fsms_menu.sv - randomized bench for fsms_menu against a cycle-level behavioural model
module tb_fsms_menu;
  localparam int ACC = 3;
  localparam int P_INIT = 0, P_READ = 1, P_DECIDE = 2, P_EDIT = 3, P_WRITE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fsms_menu_if bus();
  fsms_menu #(.ACC_CYC(ACC), .ALARM_CYC(1000)) dut (.CLK(clk), .RST(rst), .bus(bus));

  int tbl [10] = '{'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h41, 'h42, 'h43, 'h44};

  int n_cmp = 0;
  int n_bad = 0;

  int ph = P_INIT;
  int t = 0;
  int e_dir = 0;
  int e_punt = 1;
  bit e_alarm, e_pend, e_up, e_dn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: phase + elapsed cycles of the current sweep; address = table[t / ACC].
  always @(posedge clk) begin
    bit pe;
    int len;
    if (!rst) begin
      ph = P_INIT; t = 0; e_dir = 0; e_punt = 1;
      e_alarm = 0; e_pend = 0; e_up = 0; e_dn = 0;
    end else begin
      pe = e_pend || (bus.IRQ && ph != P_INIT);
      e_up = 0;
      e_dn = 0;
      if (ph != P_INIT) e_pend = pe;
      case (ph)
        P_INIT: if (bus.FRW) begin ph = P_READ; t = 0; e_dir = tbl[0]; end
        P_READ, P_WRITE: begin
          len = ((ph == P_READ) ? 10 : 9) * ACC;
          t++;
          if (t == len) begin
            if (ph == P_READ) ph = P_DECIDE;
            else begin ph = P_READ; t = 0; e_dir = tbl[0]; end
          end else begin
            e_dir = tbl[t / ACC];
          end
        end
        P_DECIDE: begin
          if (bus.Bcentro) begin
            ph = P_EDIT; e_alarm = 0; e_pend = 0;
          end else begin
            if (pe) e_alarm = 1;
            e_pend = 0;
            ph = P_READ; t = 0; e_dir = tbl[0];
          end
        end
        P_EDIT: begin
          if (bus.Bcentro) begin
            ph = P_WRITE; t = 0; e_dir = tbl[0];
          end else if (bus.Barriba || bus.Babajo) begin
            e_up = bus.Barriba && !bus.Babajo;
            e_dn = bus.Babajo && !bus.Barriba;
          end else if (bus.Bderecha != bus.Bizquierda) begin
            if (bus.Bderecha) e_punt = ((e_punt << 1) | (e_punt >> 6)) & 'h7f;
            else              e_punt = (e_punt >> 1) | ((e_punt & 1) << 6);
          end
        end
        default: ph = P_INIT;
      endcase
    end
  end

  task automatic tick();
    @(negedge clk);
    check("Acceso", bus.Acceso, (ph == P_READ || ph == P_WRITE));
    check("Mod", bus.Mod, (ph == P_EDIT));
    check("STW", bus.STW, (ph == P_WRITE));
    check("Dir", bus.Dir, e_dir);
    check("Punt", bus.Punt, e_punt);
    check("Numup", bus.Numup, e_up);
    check("Numdown", bus.Numdown, e_dn);
    check("Alarma", bus.Alarma, e_alarm);
  endtask

  task automatic set_in(input bit irq, up, dn, r, l, c, frw);
    bus.IRQ = irq; bus.Barriba = up; bus.Babajo = dn;
    bus.Bderecha = r; bus.Bizquierda = l; bus.Bcentro = c; bus.FRW = frw;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    bus.FRW = 1'b1;
    tick();
    bus.FRW = 1'b0;
    repeat (35) tick();

    for (int i = 0; i < 4000; i++) begin
      set_in($urandom_range(0, 24) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
      rst = !($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 1'b1;

    set_in(0, 0, 0, 0, 0, 1, 1);
    repeat (120) tick();

    for (int i = 0; i < 200 && ph != P_WRITE; i++) tick();
    repeat (5) tick();
    check("in_write_before_reset", (ph == P_WRITE), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fsms_menu.md
Name: fsms_menu

Overview:
Menu/control FSM for the RTC front-end. It sequences read sweeps of RTC register addresses and reacts to the five user buttons and the RTC interrupt. It enters a field-edit mode, issues increment/decrement strobes to the datapath, and triggers a write-back sweep. It sits between the button conditioners/RTC IRQ pin and the RTC bus controller, which consumes Dir/Acceso/STW.

Parameters:
ACC_CYC, 4, cycles each address is held on Dir during a sweep (>=1)
ALARM_CYC, 1000, Alarma auto-clear timeout in cycles (used only with the optional feature)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous reset, active-low; one clock, reset is synchronous and active-low
IRQ  in  1  RTC interrupt, level, may be a 1-cycle pulse
Barriba  in  1  up button, level, already debounced
Babajo  in  1  down button
Bderecha  in  1  right button
Bizquierda  in  1  left button
Bcentro  in  1  centre/enter button
FRW  in  1  RTC first-write/initialisation done
Acceso  out  1  bus access request; high while Dir is valid
Mod  out  1  edit mode active
Alarma  out  1  alarm flag
STW  out  1  write-sweep strobe; high for the whole write sweep
Dir  out  7  RTC register address
Numup  out  1  1-cycle increment strobe for the selected field
Numdown  out  1  1-cycle decrement strobe
Punt  out  7  one-hot pointer to the selected edit field

Behaviour:
- Reset (RST=0 at a clock edge): state INIT; Acceso=0, Mod=0, Alarma=0, STW=0, Numup=0, Numdown=0, Dir=7'h00, Punt=7'b0000001, sweep counters=0, irq_pend=0.
- Address table (10 entries, in order): 21,22,23,24,25,26,41,42,43,44 (hex). Read sweeps use all 10 entries. Write sweeps use the first 9 entries (21..43).
- INIT: outputs idle. Stay while FRW=0. FRW=1 -> READ on the next cycle.
- READ: Acceso=1. Dir steps through the table, each entry held ACC_CYC cycles. After the last cycle of 7'h44 -> DECIDE.
- DECIDE (1 cycle): Acceso=0, Dir holds 7'h44.
  - Bcentro=1 -> EDIT, and clear Alarma/irq_pend.
  - Otherwise, if irq_pend=1, set Alarma=1.
  - Otherwise -> READ.
  - Arrow buttons are ignored here.
- EDIT: Mod=1, Acceso=0. Per-cycle priority: Bcentro > Barriba/Babajo > Bderecha/Bizquierda.
  - Bcentro=1 -> WRITE.
  - Barriba=1 alone -> Numup=1 this cycle. Babajo=1 alone -> Numdown=1. Both high -> neither.
  - Bderecha=1 -> Punt rotates left (bit6 wraps to bit0). Bizquierda=1 -> Punt rotates right (bit0 wraps to bit6). Both high -> no move.
- WRITE: Mod=0, STW=1, Acceso=1. Dir sweeps 21..43, each held ACC_CYC cycles. At the end STW drops and the next state is READ.
- IRQ: sampled every cycle outside INIT; sets irq_pend, held until DECIDE services or clears it.
- Buttons are level-sensitive. A held Bcentro cycles DECIDE->EDIT->WRITE->READ->DECIDE repeatedly.
- Outputs are registered: first Dir of a sweep appears on the cycle after the state transition.
- Punt is retained across modes. It resets only on RST.
- FRW is ignored after INIT.

Optional Feature:
FSMS_MENU_ALARM_TIMEOUT_EN: when defined, Alarma self-clears after ALARM_CYC cycles high if not acknowledged. When undefined, Alarma stays high until Bcentro is pressed in DECIDE or reset.

Decomposition:
- Package fsms_menu_pkg holds:
  - state enum: INIT, READ, DECIDE, EDIT, WRITE
  - 10-entry address table constant
  - PUNT_RST=7'b0000001
- One natural sub-module: fsms_menu_addr_seq. Inputs are start, mode (read/write), and ACC_CYC. Outputs are Dir, valid and done.

Test Plan:
- Reset, then FRW=0 for 3 cycles, then FRW=1 -> Acceso=0 while FRW=0. Dir=7'h21 within 2 cycles of FRW=1. Dir reaches 7'h44 after 9*ACC_CYC cycles.
- Bderecha 1-cycle pulse during READ -> no state change, Mod stays 0, Punt stays 7'b0000001, READ sweep restarts after DECIDE.
- IRQ 1-cycle pulse while Dir=7'h44 -> Alarma=1 after the next DECIDE. Bcentro then held -> Alarma=0 and Mod=1.
- Bcentro held continuously -> Mod=1 for 1 cycle, then STW=1 with Dir sweeping 21..43 (9*ACC_CYC cycles), then STW=0 and Dir returns to 7'h21.
- In EDIT: Bderecha x7 -> Punt walks bit0..bit6 and back to 7'b0000001. Bizquierda once from reset value -> 7'b1000000.
- In EDIT: Barriba pulse -> Numup=1 for exactly 1 cycle. Barriba+Babajo together -> no strobes. RST=0 mid-WRITE -> STW=0 and INIT on the next edge.
